// File: rtl/mac_vec_fp16.sv
// rtl/mac_vec_fp16.sv - LANES-wide FP16 multiply, adder-tree reduce and accumulate; option MAC_VEC_FP16_BIAS_INIT_EN
module mac_vec_fp16 #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] in_a,
   input  logic [LANES*DATA_WIDTH-1:0] in_b,
   input  logic [CNT_WIDTH-1:0]        clk_num,
`ifdef MAC_VEC_FP16_BIAS_INIT_EN
   input  logic [DATA_WIDTH-1:0]       bias_in,
`endif
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_result,
   output logic                        busy
);

   localparam int          LVL  = $clog2(LANES);
   localparam logic [15:0] QNAN = 16'h7e00;

   // Rounds a normalised significand (hidden bit in m[10]) to nearest-even, then
   // saturates to inf or flushes to signed zero when the exponent leaves the normal range.
   function automatic logic [15:0] pack_round(input logic s, input logic signed [7:0] e,
                                              input logic [10:0] m, input logic g, input logic st);
      logic [11:0]       mr;
      logic signed [7:0] er;
      mr = {1'b0, m} + {11'd0, g & (st | m[0])};
      er = e;
      if (mr[11]) begin
         mr = {1'b0, mr[11:1]};
         er = e + 8'sd1;
      end
      if (er >= 8'sd31)     pack_round = {s, 5'h1f, 10'h000};
      else if (er <= 8'sd0) pack_round = {s, 15'h0000};
      else                  pack_round = {s, er[4:0], mr[9:0]};
   endfunction

   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic              s, za, zb, ia, ib, na, nb;
      logic [21:0]       sig;
      logic signed [7:0] e;
      s   = a[15] ^ b[15];
      za  = (a[14:10] == 5'h00);
      zb  = (b[14:10] == 5'h00);
      ia  = (a[14:10] == 5'h1f) && (a[9:0] == 10'h000);
      ib  = (b[14:10] == 5'h1f) && (b[9:0] == 10'h000);
      na  = (a[14:10] == 5'h1f) && (a[9:0] != 10'h000);
      nb  = (b[14:10] == 5'h1f) && (b[9:0] != 10'h000);
      sig = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
      e   = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
      if (na || nb || (ia && zb) || (ib && za)) fp16_mul = QNAN;
      else if (ia || ib)                        fp16_mul = {s, 5'h1f, 10'h000};
      else if (za || zb)                        fp16_mul = {s, 15'h0000};
      else if (sig[21])                         fp16_mul = pack_round(s, e + 8'sd1, sig[21:11], sig[10], |sig[9:0]);
      else                                      fp16_mul = pack_round(s, e, sig[20:10], sig[9], |sig[8:0]);
   endfunction

   // Smaller operand is aligned into a 14-bit significand with guard, round and sticky bits.
   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic              za, zb, ia, ib, na, nb;
      logic [15:0]       x, y;
      logic [4:0]        d;
      logic [26:0]       ext;
      logic [13:0]       bx, sy, n;
      logic [14:0]       r;
      logic signed [7:0] e;
      za = (a[14:10] == 5'h00);
      zb = (b[14:10] == 5'h00);
      ia = (a[14:10] == 5'h1f) && (a[9:0] == 10'h000);
      ib = (b[14:10] == 5'h1f) && (b[9:0] == 10'h000);
      na = (a[14:10] == 5'h1f) && (a[9:0] != 10'h000);
      nb = (b[14:10] == 5'h1f) && (b[9:0] != 10'h000);
      if (a[14:0] >= b[14:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d = x[14:10] - y[14:10];
      if (d > 5'd15) d = 5'd15;
      ext = {1'b1, y[9:0], 16'h0000} >> d;
      bx  = {1'b1, x[9:0], 3'b000};
      sy  = {ext[26:14], ext[13] | (|ext[12:0])};
      if (x[15] == y[15]) r = {1'b0, bx} + {1'b0, sy};
      else                r = {1'b0, bx} - {1'b0, sy};
      e = $signed({3'b000, x[14:10]});
      n = r[13:0];
      if (r[14]) begin
         n = {r[14:2], r[1] | r[0]};
         e = e + 8'sd1;
      end else begin
         for (int i = 0; i < 13; i++) begin
            if (!n[13]) begin
               n = n << 1;
               e = e - 8'sd1;
            end
         end
      end
      if (na || nb || (ia && ib && (a[15] != b[15]))) fp16_add = QNAN;
      else if (ia)                                    fp16_add = a;
      else if (ib)                                    fp16_add = b;
      else if (za && zb)                              fp16_add = 16'h0000;
      else if (za)                                    fp16_add = b;
      else if (zb)                                    fp16_add = a;
      else if (r == 15'd0)                            fp16_add = 16'h0000;
      else                                            fp16_add = pack_round(x[15], e, n[13:3], n[2], |n[1:0]);
   endfunction

   logic [CNT_WIDTH-1:0] cnt, num_q, eff_num;
   logic                 first_beat, last_beat;
   logic [15:0]          stg [0:LVL][0:LANES-1];
   logic [LVL:0]         v_q, f_q, l_q;
   logic [15:0]          acc_q, acc_next;
`ifdef MAC_VEC_FP16_BIAS_INIT_EN
   logic [15:0]          bias_q [0:LVL];
`endif

   // Tags the incoming beat as first/last of its group; clk_num only matters on a first beat
   always_comb begin
      first_beat = (cnt == '0);
      eff_num    = num_q;
      if (first_beat) eff_num = (clk_num == '0) ? CNT_WIDTH'(1) : clk_num;
      last_beat  = (cnt == eff_num - CNT_WIDTH'(1));
   end

   // Beat counter and latched group length; bubbles leave both untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         num_q <= '0;
      end else if (in_valid) begin
         if (first_beat) num_q <= eff_num;
         cnt <= last_beat ? '0 : cnt + CNT_WIDTH'(1);
      end
   end

   // Product stage and adder-tree levels; validity is carried by the tag pipeline
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         stg[0][i] <= fp16_mul(in_a[DATA_WIDTH*i +: DATA_WIDTH], in_b[DATA_WIDTH*i +: DATA_WIDTH]);
      for (int l = 1; l <= LVL; l++) begin
         for (int k = 0; k < LANES / 2; k++)
            stg[l][k] <= fp16_add(stg[l-1][2*k], stg[l-1][2*k+1]);
         for (int k = LANES / 2; k < LANES; k++)
            stg[l][k] <= '0;
      end
`ifdef MAC_VEC_FP16_BIAS_INIT_EN
      bias_q[0] <= bias_in;
      for (int l = 1; l <= LVL; l++) bias_q[l] <= bias_q[l-1];
`endif
   end

   // Valid/first/last tags travelling alongside the data
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         f_q <= '0;
         l_q <= '0;
      end else begin
         v_q[0] <= in_valid;
         f_q[0] <= first_beat;
         l_q[0] <= last_beat;
         for (int l = 1; l <= LVL; l++) begin
            v_q[l] <= v_q[l-1];
            f_q[l] <= f_q[l-1];
            l_q[l] <= l_q[l-1];
         end
      end
   end

   // Accumulator input: a first beat restarts the sum, any other beat adds to it
   always_comb begin
`ifdef MAC_VEC_FP16_BIAS_INIT_EN
      acc_next = fp16_add(f_q[LVL] ? bias_q[LVL] : acc_q, stg[LVL][0]);
`else
      acc_next = f_q[LVL] ? stg[LVL][0] : fp16_add(acc_q, stg[LVL][0]);
`endif
   end

   // Accumulate stage; a last beat publishes the result with a one-cycle pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         out_valid <= v_q[LVL] & l_q[LVL];
         if (v_q[LVL]) acc_q <= acc_next;
         if (v_q[LVL] && l_q[LVL]) out_result <= acc_next;
      end
   end

   assign busy = (cnt != '0) || (|v_q);

endmodule
